// File: rtl/stage3_ex_pkg.sv
// Shared definitions for the execute stage: bus widths, divide-op encodings,
// bus field positions, the divider state type and the latched ID->EX payload.
package stage3_ex_pkg;

  localparam int WIDTH_DS_TO_ES_BUS = 151;
  localparam int WIDTH_ES_TO_MS_BUS = 71;
  localparam int WIDTH_ES_TO_DS_BUS = 39;

  // div_op encodings; anything with bit 2 clear is not a divide
  localparam logic [2:0] DIV_W  = 3'b110;
  localparam logic [2:0] MOD_W  = 3'b111;
  localparam logic [2:0] DIV_WU = 3'b100;
  localparam logic [2:0] MOD_WU = 3'b101;

  localparam int DIV_OP_IS_DIV = 2;
  localparam int DIV_OP_SIGNED = 1;
  localparam int DIV_OP_REM    = 0;

  // es_to_ms_bus field positions
  localparam int ES_MS_PC_LSB       = 0;
  localparam int ES_MS_GR_WE        = 32;
  localparam int ES_MS_RES_FROM_MEM = 33;
  localparam int ES_MS_DEST_LSB     = 34;
  localparam int ES_MS_RESULT_LSB   = 39;

  // es_to_ds_bus field positions
  localparam int ES_DS_RESULT_LSB = 0;
  localparam int ES_DS_DEST_LSB   = 32;
  localparam int ES_DS_GR_WE      = 37;
  localparam int ES_DS_LOAD       = 38;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Field order mirrors ds_to_es_bus, MSB first
  typedef struct packed {
    logic [2:0]  div_op;
    logic [11:0] alu_op;
    logic [4:0]  dest;
    logic        res_from_mem;
    logic        mem_we;
    logic        gr_we;
    logic [31:0] rkd_value;
    logic [31:0] alu_src2;
    logic [31:0] alu_src1;
    logic [31:0] pc;
  } ds_to_es_t;

  // Magnitude of a value, treating it as two's complement only when is_signed
  function automatic logic [31:0] abs32(input logic [31:0] value, input logic is_signed);
    return (is_signed && value[31]) ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU shared by the pipeline; alu_op is one-hot:
// 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra, 11 lui.
module alu (
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);

  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;
  logic        slt_bit;
  logic        sltu_bit;

  assign add_res  = alu_src1 + alu_src2;
  assign sub_res  = alu_src1 - alu_src2;
  assign slt_bit  = $signed(alu_src1) < $signed(alu_src2);
  assign sltu_bit = alu_src1 < alu_src2;
  assign sll_res  = alu_src1 << alu_src2[4:0];
  assign srl_res  = alu_src1 >> alu_src2[4:0];
  assign sra_res  = $signed(alu_src1) >>> alu_src2[4:0];

  // Merge the selected operation's result; no op selected yields zero
  always_comb begin
    alu_result = 32'd0;
    if (alu_op[0])  alu_result = alu_result | add_res;
    if (alu_op[1])  alu_result = alu_result | sub_res;
    if (alu_op[2])  alu_result = alu_result | {31'd0, slt_bit};
    if (alu_op[3])  alu_result = alu_result | {31'd0, sltu_bit};
    if (alu_op[4])  alu_result = alu_result | (alu_src1 & alu_src2);
    if (alu_op[5])  alu_result = alu_result | ~(alu_src1 | alu_src2);
    if (alu_op[6])  alu_result = alu_result | (alu_src1 | alu_src2);
    if (alu_op[7])  alu_result = alu_result | (alu_src1 ^ alu_src2);
    if (alu_op[8])  alu_result = alu_result | sll_res;
    if (alu_op[9])  alu_result = alu_result | srl_res;
    if (alu_op[10]) alu_result = alu_result | sra_res;
    if (alu_op[11]) alu_result = alu_result | alu_src2;
  end

endmodule

// File: rtl/stage3_ex_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on operand
// magnitudes, signs applied on the way out. Result holds in DONE until ack.
module div_iter
  import stage3_ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  state;
  div_state_e  state_next;
  logic [5:0]  count;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] div_mag;
  logic        neg_quo;
  logic        neg_rem;
  logic [32:0] rem_shift;
  logic [31:0] rem_diff;
  logic        fits;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  // A zero divisor always "fits", which leaves quotient all ones and the
  // remainder equal to the dividend magnitude.
  assign rem_shift = {rem_mag, quo_mag[31]};
  assign fits      = rem_shift >= {1'b0, div_mag};
  assign rem_diff  = rem_shift[31:0] - div_mag;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_next;
  end

  // Next-state: start from IDLE, 32 iterations in BUSY, hold DONE until ack
  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: if (start)          state_next = DIV_BUSY;
      DIV_BUSY: if (count == 6'd31) state_next = DIV_DONE;
      DIV_DONE: if (ack)            state_next = DIV_IDLE;
      default:                      state_next = DIV_IDLE;
    endcase
  end

  // Datapath: capture magnitudes and result signs at start, iterate while busy
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= 6'd0;
      quo_mag <= 32'd0;
      rem_mag <= 32'd0;
      div_mag <= 32'd0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            count   <= 6'd0;
            quo_mag <= abs32(dividend, signed_op);
            div_mag <= abs32(divisor, signed_op);
            rem_mag <= 32'd0;
            neg_quo <= signed_op && (dividend[31] ^ divisor[31]);
            neg_rem <= signed_op && dividend[31];
          end
        end
        DIV_BUSY: begin
          count <= count + 6'd1;
          if (fits) begin
            rem_mag <= rem_diff;
            quo_mag <= {quo_mag[30:0], 1'b1};
          end else begin
            rem_mag <= rem_shift[31:0];
            quo_mag <= {quo_mag[30:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == DIV_BUSY);
  assign done      = (state == DIV_DONE);
  assign quotient  = neg_quo ? (~quo_mag + 32'd1) : quo_mag;
  assign remainder = neg_rem ? (~rem_mag + 32'd1) : rem_mag;

endmodule

// File: rtl/stage3_ex.sv
// Execute stage: latches the decoded instruction from ID, computes its result
// on the ALU or the iterative divider, issues the data SRAM request and
// feeds MEM and the ID forwarding path.
module stage3_ex
  import stage3_ex_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ms_allow_in,
  output logic                          es_allow_in,
  input  logic                          ds_to_es_valid,
  output logic                          es_to_ms_valid,
  input  logic [WIDTH_DS_TO_ES_BUS-1:0] ds_to_es_bus,
  output logic [WIDTH_ES_TO_MS_BUS-1:0] es_to_ms_bus,
  output logic [WIDTH_ES_TO_DS_BUS-1:0] es_to_ds_bus,
  output logic                          data_sram_en,
  output logic [3:0]                    data_sram_we,
  output logic [31:0]                   data_sram_addr,
  output logic [31:0]                   data_sram_wdata
);

  ds_to_es_t   es_inst;
  logic        es_valid;
  logic        es_ready_go;
  logic        is_div;
  logic        div_start;
  logic        div_ack;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic [31:0] div_result;
  logic [31:0] alu_result;
  logic [31:0] es_result;

  assign is_div         = es_inst.div_op[DIV_OP_IS_DIV];
  assign es_ready_go    = !is_div || div_done;
  assign es_allow_in    = !es_valid || (es_ready_go && ms_allow_in);
  assign es_to_ms_valid = es_valid && es_ready_go;

  // Stage valid bit follows ID whenever this stage can accept
  always_ff @(posedge clk) begin
    if (reset)            es_valid <= 1'b0;
    else if (es_allow_in) es_valid <= ds_to_es_valid;
  end

  // Instruction payload loads only on a real handoff and holds while stalled
  always_ff @(posedge clk) begin
    if (reset)                              es_inst <= '0;
    else if (ds_to_es_valid && es_allow_in) es_inst <= ds_to_es_t'(ds_to_es_bus);
  end

  alu u_alu (
    .alu_op     (es_inst.alu_op),
    .alu_src1   (es_inst.alu_src1),
    .alu_src2   (es_inst.alu_src2),
    .alu_result (alu_result)
  );

  // A divide starts in its first EX cycle and is released when it leaves EX
  assign div_start = es_valid && is_div && !div_busy && !div_done;
  assign div_ack   = es_to_ms_valid && ms_allow_in;

  div_iter u_div_iter (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .signed_op (es_inst.div_op[DIV_OP_SIGNED]),
    .dividend  (es_inst.alu_src1),
    .divisor   (es_inst.alu_src2),
    .ack       (div_ack),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  assign div_result = es_inst.div_op[DIV_OP_REM] ? div_remainder : div_quotient;
  assign es_result  = is_div ? div_result : alu_result;

  assign es_to_ms_bus[ES_MS_PC_LSB +: 32]     = es_inst.pc;
  assign es_to_ms_bus[ES_MS_GR_WE]            = es_inst.gr_we;
  assign es_to_ms_bus[ES_MS_RES_FROM_MEM]     = es_inst.res_from_mem;
  assign es_to_ms_bus[ES_MS_DEST_LSB +: 5]    = es_inst.dest;
  assign es_to_ms_bus[ES_MS_RESULT_LSB +: 32] = es_result;

  assign es_to_ds_bus[ES_DS_RESULT_LSB +: 32] = es_result;
  assign es_to_ds_bus[ES_DS_DEST_LSB +: 5]    = es_inst.dest;
  assign es_to_ds_bus[ES_DS_GR_WE]            = es_valid && es_inst.gr_we;
  assign es_to_ds_bus[ES_DS_LOAD]             = es_valid && es_inst.res_from_mem;

  // Word-only memory request, gated by MEM being able to take the response
  assign data_sram_en    = es_valid && (es_inst.res_from_mem || es_inst.mem_we) && ms_allow_in;
  assign data_sram_we    = {4{es_valid && es_inst.mem_we && ms_allow_in}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = es_inst.rkd_value;

endmodule

// File: tb/tb_stage3_ex.sv
// Bench for the execute stage: table of ALU/divide vectors with a result
// scoreboard, plus sequences for stalls, memory requests and mid-divide reset.
module tb_stage3_ex;
  import stage3_ex_pkg::*;

  localparam logic [11:0] OP_ADD  = 12'h001;
  localparam logic [11:0] OP_SUB  = 12'h002;
  localparam logic [11:0] OP_SLT  = 12'h004;
  localparam logic [11:0] OP_SLTU = 12'h008;
  localparam logic [11:0] OP_XOR  = 12'h080;
  localparam logic [11:0] OP_SRA  = 12'h400;
  localparam logic [11:0] OP_LUI  = 12'h800;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allow_in;
  logic         es_allow_in;
  logic         ds_to_es_valid;
  logic         es_to_ms_valid;
  logic [150:0] ds_to_es_bus;
  logic [70:0]  es_to_ms_bus;
  logic [38:0]  es_to_ds_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  stage3_ex dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allow_in     (ms_allow_in),
    .es_allow_in     (es_allow_in),
    .ds_to_es_valid  (ds_to_es_valid),
    .es_to_ms_valid  (es_to_ms_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_bus    (es_to_ms_bus),
    .es_to_ds_bus    (es_to_ds_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  div_op;
    logic [11:0] alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] result;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] result;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_seq = 32'h1c00_0000;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // Called just after a rising edge; the instruction is taken on the next edge
  task automatic applyStimulus(input logic [2:0] div_op, input logic [11:0] alu_op,
                               input logic [4:0] dest, input logic res_from_mem,
                               input logic mem_we, input logic gr_we,
                               input logic [31:0] rkd, input logic [31:0] src2,
                               input logic [31:0] src1, input logic [31:0] result);
    ds_to_es_bus   = {div_op, alu_op, dest, res_from_mem, mem_we, gr_we, rkd, src2, src1, pc_seq};
    ds_to_es_valid = 1'b1;
    sb.push_back('{pc_seq, dest, result});
    @(posedge clk);
    #1;
    ds_to_es_valid = 1'b0;
    pc_seq         = pc_seq + 32'd4;
  endtask

  // Count cycles from the first EX cycle until es_to_ms_valid, bounded
  task automatic waitValid(output int lat);
    lat = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (es_to_ms_valid) break;
      lat++;
    end
  endtask

  task automatic waitDone(input string name, input int expect_lat);
    int lat;
    waitValid(lat);
    checkOutput({name, " latency"}, lat, expect_lat);
    checkOutput({name, " fwd gr_we"}, es_to_ds_bus[37], 1'b1);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every instruction leaving EX must match the oldest expectation
  always @(negedge clk) begin : monitor
    sb_t e;
    if (!reset && es_to_ms_valid && ms_allow_in) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected es_to_ms_valid", es_to_ms_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        checkOutput("ms result", es_to_ms_bus[70:39], e.result);
        checkOutput("ds result", es_to_ds_bus[31:0], e.result);
        checkOutput("ms pc", es_to_ms_bus[31:0], e.pc);
        checkOutput("ms dest", es_to_ms_bus[38:34], e.dest);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    int cnt;
    int lat;

    vecs.push_back('{"add 5+7",        3'b000, OP_ADD,  32'd5,          32'd7,          32'd12,         0});
    vecs.push_back('{"sub 5-7",        3'b000, OP_SUB,  32'd5,          32'd7,          32'hFFFF_FFFE,  0});
    vecs.push_back('{"xor",            3'b000, OP_XOR,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'hFF00_FF00,  0});
    vecs.push_back('{"slt -1<1",       3'b000, OP_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,          0});
    vecs.push_back('{"sltu max<1",     3'b000, OP_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,          0});
    vecs.push_back('{"sra",            3'b000, OP_SRA,  32'h8000_0000,  32'd4,          32'hF800_0000,  0});
    vecs.push_back('{"lui",            3'b000, OP_LUI,  32'd0,          32'h1234_5000,  32'h1234_5000,  0});
    vecs.push_back('{"div.w -7/2",     DIV_W,  12'd0,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
    vecs.push_back('{"mod.w -7/2",     MOD_W,  12'd0,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
    vecs.push_back('{"div.wu 100/0",   DIV_WU, 12'd0,   32'd100,        32'd0,          32'hFFFF_FFFF,  33});
    vecs.push_back('{"mod.wu 100/0",   MOD_WU, 12'd0,   32'd100,        32'd0,          32'd100,        33});
    vecs.push_back('{"div.w min/-1",   DIV_W,  12'd0,   32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33});
    vecs.push_back('{"mod.w min/-1",   MOD_W,  12'd0,   32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33});
    vecs.push_back('{"div.wu max/3",   DIV_WU, 12'd0,   32'hFFFF_FFFF,  32'd3,          32'h5555_5555,  33});
    vecs.push_back('{"mod.wu max/10",  MOD_WU, 12'd0,   32'hFFFF_FFFF,  32'd10,         32'd5,          33});
    vecs.push_back('{"div.w 7/-2",     DIV_W,  12'd0,   32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33});
    vecs.push_back('{"mod.w 7/-2",     MOD_W,  12'd0,   32'd7,          32'hFFFF_FFFE,  32'd1,          33});
    vecs.push_back('{"div.w -100/0",   DIV_W,  12'd0,   32'hFFFF_FF9C,  32'd0,          32'd1,          33});
    vecs.push_back('{"mod.w -100/0",   MOD_W,  12'd0,   32'hFFFF_FF9C,  32'd0,          32'hFFFF_FF9C,  33});

    // Reset with a valid store presented: nothing may leak out
    reset          = 1'b1;
    ms_allow_in    = 1'b1;
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = {3'b000, OP_ADD, 5'd0, 1'b0, 1'b1, 1'b0, 32'h1111_2222, 32'd0, 32'h40, 32'h0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset es_allow_in", es_allow_in, 1'b1);
    checkOutput("reset es_to_ms_valid", es_to_ms_valid, 1'b0);
    checkOutput("reset es_to_ms_bus", es_to_ms_bus, 71'd0);
    checkOutput("reset es_to_ds_bus", es_to_ds_bus, 39'd0);
    checkOutput("reset sram_en", data_sram_en, 1'b0);
    checkOutput("reset sram_we", data_sram_we, 4'h0);
    checkOutput("reset sram_addr", data_sram_addr, 32'd0);
    checkOutput("reset sram_wdata", data_sram_wdata, 32'd0);
    @(posedge clk);
    #1;
    ds_to_es_valid = 1'b0;
    ds_to_es_bus   = '0;
    reset          = 1'b0;

    // Table-driven ALU and divide vectors
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].div_op, vecs[i].alu_op, 5'(i + 1), 1'b0, 1'b0, 1'b1,
                    32'd0, vecs[i].src2, vecs[i].src1, vecs[i].result);
      waitDone(vecs[i].name, vecs[i].lat);
    end

    // Divide finishes while MEM is stalled: result must hold in DONE
    applyStimulus(DIV_WU, 12'd0, 5'd9, 1'b0, 1'b0, 1'b1, 32'd0, 32'd7, 32'd100, 32'd14);
    ms_allow_in = 1'b0;
    waitValid(lat);
    checkOutput("stall div latency", lat, 33);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput("stall es_to_ms_valid", es_to_ms_valid, 1'b1);
      checkOutput("stall es_allow_in", es_allow_in, 1'b0);
      checkOutput("stall es_result", es_to_ms_bus[70:39], 32'd14);
    end
    @(posedge clk);
    #1;
    ms_allow_in = 1'b1;
    @(negedge clk);
    checkOutput("release es_allow_in", es_allow_in, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("released es_to_ms_valid", es_to_ms_valid, 1'b0);
    @(posedge clk);
    #1;

    // Store request
    applyStimulus(3'b000, OP_ADD, 5'd0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0, 32'h1000, 32'h1000);
    @(negedge clk);
    checkOutput("st sram_en", data_sram_en, 1'b1);
    checkOutput("st sram_we", data_sram_we, 4'hF);
    checkOutput("st sram_addr", data_sram_addr, 32'h1000);
    checkOutput("st sram_wdata", data_sram_wdata, 32'hDEAD_BEEF);
    checkOutput("st fwd gr_we", es_to_ds_bus[37], 1'b0);
    @(posedge clk);
    #1;

    // Load request
    applyStimulus(3'b000, OP_ADD, 5'd4, 1'b1, 1'b0, 1'b1, 32'd0, 32'd4, 32'h2000, 32'h2004);
    @(negedge clk);
    checkOutput("ld sram_en", data_sram_en, 1'b1);
    checkOutput("ld sram_we", data_sram_we, 4'h0);
    checkOutput("ld sram_addr", data_sram_addr, 32'h2004);
    checkOutput("ld fwd load", es_to_ds_bus[38], 1'b1);
    @(posedge clk);
    #1;

    // Store while MEM cannot accept: no request until released
    ms_allow_in = 1'b0;
    applyStimulus(3'b000, OP_ADD, 5'd0, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 32'd8, 32'h3000, 32'h3008);
    @(negedge clk);
    checkOutput("blocked st sram_en", data_sram_en, 1'b0);
    checkOutput("blocked st sram_we", data_sram_we, 4'h0);
    checkOutput("blocked es_allow_in", es_allow_in, 1'b0);
    @(posedge clk);
    #1;
    ms_allow_in = 1'b1;
    @(negedge clk);
    checkOutput("unblocked st sram_en", data_sram_en, 1'b1);
    checkOutput("unblocked st sram_we", data_sram_we, 4'hF);
    @(posedge clk);
    #1;

    // Reset in the tenth cycle after a divide starts
    applyStimulus(DIV_W, 12'd0, 5'd3, 1'b0, 1'b0, 1'b1, 32'd0, 32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFD);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post-reset es_to_ms_valid", es_to_ms_valid, 1'b0);
    checkOutput("post-reset es_allow_in", es_allow_in, 1'b1);
    checkOutput("post-reset sram_en", data_sram_en, 1'b0);
    checkOutput("post-reset fwd flags", es_to_ds_bus[38:37], 2'b00);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (es_to_ms_valid || data_sram_en) cnt++;
    end
    checkOutput("post-reset idle outputs", cnt, 0);
    @(posedge clk);
    #1;
    applyStimulus(DIV_W, 12'd0, 5'd3, 1'b0, 1'b0, 1'b1, 32'd0, 32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFD);
    waitDone("div.w after reset", 33);

    repeat (2) @(posedge clk);
    checkOutput("scoreboard drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
